compress_packer: RTL

//  Downstream of the per-word compressor. Packs variable-length fragments ({bitmap, length, data}: 0/8/16/32 bits)
//  LSB-first into fixed OUT_W-bit data words. Packs the 2-bit bitmaps, OUT_W/2 per word, into a separate bitmap stream.

---
 rtl/compress_packer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/compress_packer.sv
// Packs 0/8/16/32-bit fragments LSB-first into OUT_W-bit data words and their 2-bit
// bitmaps into a parallel bitmap stream; a last-flagged fragment flushes both streams.
module compress_packer #(
   parameter int OUT_W = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_bitmap,
   input  logic [9:0]                 in_length,
   input  logic [31:0]                in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_last,
   output logic [$clog2(OUT_W/8):0]   out_bytes,
   output logic                       bm_valid,
   input  logic                       bm_ready,
   output logic [OUT_W-1:0]           bm_data,
   output logic                       bm_last,
   output logic [$clog2(OUT_W/2):0]   bm_count,
   output logic                       err_len
);
   localparam int BYTES_W = $clog2(OUT_W/8) + 1;
   localparam int BMC_W   = $clog2(OUT_W/2) + 1;
   localparam int ACC_W   = OUT_W + 32;
   localparam int FILL_W  = $clog2(ACC_W) + 1;
   localparam logic [BYTES_W-1:0] FULL_BYTES   = BYTES_W'(OUT_W/8);
   localparam logic [BMC_W-1:0]   FULL_ENTRIES = BMC_W'(OUT_W/2);
   localparam logic [FILL_W-1:0]  WORD_BITS    = FILL_W'(OUT_W);

   typedef enum logic {RUN, FLUSH} state_t;

   function automatic logic [5:0] frag_len(input logic [1:0] bm);
      case (bm)
         2'b00:   frag_len = 6'd0;
         2'b01:   frag_len = 6'd8;
         2'b10:   frag_len = 6'd16;
         default: frag_len = 6'd32;
      endcase
   endfunction

   function automatic logic [31:0] frag_mask(input logic [1:0] bm);
      case (bm)
         2'b00:   frag_mask = 32'h0000_0000;
         2'b01:   frag_mask = 32'h0000_00FF;
         2'b10:   frag_mask = 32'h0000_FFFF;
         default: frag_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   state_t              r_state, w_state_nx;
   logic [ACC_W-1:0]    r_acc;
   logic [FILL_W-1:0]   r_fill;
   logic [OUT_W-1:0]    r_bm_acc;
   logic [BMC_W-1:0]    r_bm_cnt;
   logic                r_pend_d, r_pend_b;

   logic                w_accept, w_out_hs, w_bm_hs, w_dload, w_bload;
   logic [5:0]          w_len;
   logic [ACC_W-1:0]    w_acc_sum;
   logic [FILL_W-1:0]   w_fill_sum, w_resid;
   logic                w_emit, w_emit_exact;
   logic [OUT_W-1:0]    w_bm_sum;
   logic [BMC_W-1:0]    w_bm_cnt_nx;
   logic                w_bm_full;

   assign in_ready     = (r_state == RUN) & (!out_valid | out_ready) & (!bm_valid | bm_ready);
   assign w_accept     = in_valid & in_ready;
   assign w_out_hs     = out_valid & out_ready;
   assign w_bm_hs      = bm_valid & bm_ready;
   assign w_len        = frag_len(in_bitmap);
   assign w_acc_sum    = r_acc | ({{(ACC_W-32){1'b0}}, in_data & frag_mask(in_bitmap)} << r_fill);
   assign w_fill_sum   = r_fill + FILL_W'(w_len);
   assign w_resid      = w_fill_sum - WORD_BITS;
   assign w_emit       = (w_fill_sum >= WORD_BITS);
   assign w_emit_exact = w_emit & (w_resid == '0);
   assign w_bm_sum     = r_bm_acc | ({{(OUT_W-2){1'b0}}, in_bitmap} << {r_bm_cnt, 1'b0});
   assign w_bm_cnt_nx  = r_bm_cnt + 1'b1;
   assign w_bm_full    = (w_bm_cnt_nx == FULL_ENTRIES);
   // Final words wait in the accumulators until their output register frees up.
   assign w_dload      = (r_state == FLUSH) & r_pend_d & (!out_valid | out_ready);
   assign w_bload      = (r_state == FLUSH) & r_pend_b & (!bm_valid | bm_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         RUN:   if (w_accept & in_last & (!w_emit_exact | !w_bm_full)) w_state_nx = FLUSH;
         FLUSH: if ((!r_pend_d | w_dload) & (!r_pend_b | w_bload)) w_state_nx = RUN;
         default: w_state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_d <= 1'b0;
         r_pend_b <= 1'b0;
         err_len  <= 1'b0;
      end else begin
         if (w_accept & in_last) begin
            r_pend_d <= !w_emit_exact;
            r_pend_b <= !w_bm_full;
         end else begin
            if (w_dload) r_pend_d <= 1'b0;
            if (w_bload) r_pend_b <= 1'b0;
         end
         if (w_accept & (in_length != 10'(w_len))) err_len <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_fill <= '0;
      end else if (w_accept) begin
         r_acc  <= w_emit ? (w_acc_sum >> OUT_W) : w_acc_sum;
         r_fill <= w_emit ? w_resid : w_fill_sum;
      end else if (w_dload) begin
         r_acc  <= '0;
         r_fill <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_bytes <= '0;
      end else if (w_accept & w_emit) begin
         out_valid <= 1'b1;
         out_data  <= w_acc_sum[OUT_W-1:0];
         out_last  <= in_last & w_emit_exact;
         out_bytes <= FULL_BYTES;
      end else if (w_dload) begin
         out_valid <= 1'b1;
         out_data  <= r_acc[OUT_W-1:0];
         out_last  <= 1'b1;
         out_bytes <= BYTES_W'(r_fill >> 3);
      end else if (w_out_hs) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_bytes <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bm_acc <= '0;
         r_bm_cnt <= '0;
      end else if (w_accept) begin
         r_bm_acc <= w_bm_full ? '0 : w_bm_sum;
         r_bm_cnt <= w_bm_full ? '0 : w_bm_cnt_nx;
      end else if (w_bload) begin
         r_bm_acc <= '0;
         r_bm_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bm_valid <= 1'b0;
         bm_data  <= '0;
         bm_last  <= 1'b0;
         bm_count <= '0;
      end else if (w_accept & w_bm_full) begin
         bm_valid <= 1'b1;
         bm_data  <= w_bm_sum;
         bm_last  <= in_last;
         bm_count <= FULL_ENTRIES;
      end else if (w_bload) begin
         bm_valid <= 1'b1;
         bm_data  <= r_bm_acc;
         bm_last  <= 1'b1;
         bm_count <= r_bm_cnt;
      end else if (w_bm_hs) begin
         bm_valid <= 1'b0;
         bm_data  <= '0;
         bm_last  <= 1'b0;
         bm_count <= '0;
      end
   end

endmodule
